serial_dac_mc: RTL

- Multi-channel, parametrised serial-input DAC model for the sine-wave bench.
- Receives framed serial words on SI: a channel address followed by an NBITS data code, MSB first.
- Stores each code in a per-channel input register.
- Drives one real analog output per channel, either immediately or on a global load strobe (double-buffered).
- Supersedes the single-channel fixed 12-bit serial DAC. Adds channel addressing, a configurable width, synchronous update and frame-error detection.

---
 rtl/serial_dac_mc.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_dac_mc.sv
// Multi-channel serial-input DAC model: framed {address, code} words arrive MSB first on SI
// and land in per-channel input registers, optionally double-buffered behind a global ldac strobe.
module serial_dac_mc #(
  parameter int  NBITS       = 12,
  parameter int  NCH         = 4,
  parameter real VREF        = 1.0,
  parameter int  UPDATE_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic SI,
  input  logic soc,
  input  logic en_SI,
  input  logic ldac,
  output real  A_out [NCH],
  output logic busy,
  output logic frame_err
);

  localparam int ADDR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FLEN   = ADDR_W + NBITS;
  localparam int CNT_W  = $clog2(FLEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [FLEN-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]   input_reg_q [NCH];
  logic [NBITS-1:0]   input_reg_d [NCH];
  logic [NBITS-1:0]   dac_reg_q [NCH];
  logic [NBITS-1:0]   dac_reg_d [NCH];
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr;
  logic [NBITS-1:0]   code;

  assign addr = shift_q[FLEN-1 -: ADDR_W];
  assign code = shift_q[NBITS-1:0];

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    input_reg_d = input_reg_q;
    dac_reg_d   = dac_reg_q;
    err_d       = 1'b0;

    // ldac copies the pre-edge input registers, so a commit on the same edge waits for the next ldac.
    if (UPDATE_MODE == 1 && ldac) begin
      dac_reg_d = input_reg_q;
    end

    unique case (state_q)
      IDLE: begin
        if (soc) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (soc) begin
          err_d   = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
        end else if (en_SI) begin
          shift_d = {shift_q[FLEN-2:0], SI};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(FLEN - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (int'(addr) < NCH) begin
          input_reg_d[addr] = code;
          if (UPDATE_MODE == 0) begin
            dac_reg_d[addr] = code;
          end
        end else begin
          err_d = 1'b1;
        end
        shift_d = '0;
        cnt_d   = '0;
        state_d = soc ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: the register arrays are reset too; the model must present 0.0 on every channel after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      input_reg_q <= '{default: '0};
      dac_reg_q   <= '{default: '0};
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      input_reg_q <= input_reg_d;
      dac_reg_q   <= dac_reg_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      A_out[i] = real'(dac_reg_q[i]) * VREF / (2.0 ** NBITS);
    end
  end

  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule
